// File: rtl/nib_track_writer_if.sv
// SD write-back bus between nib_track_writer and the hps_io sd_* port.
//
// Handshake: the writer raises sd_wr with a valid sd_lba and holds both
// steady until hps_io answers with sd_ack. sd_ack stays high for one whole
// sector. While it is high, hps_io walks sd_buff_addr and samples sd_buff_din
// one cycle after each address. The ack rising edge accepts the sector. The
// falling edge ends it. A new sector starts only after that fall.
interface nib_track_writer_if #(
    parameter int LBA_W = 32
);
    logic [LBA_W-1:0] sd_lba;
    logic             sd_wr;
    logic             sd_ack;
    logic [8:0]       sd_buff_addr;
    logic [7:0]       sd_buff_din;

    modport master (
        output sd_lba,
        output sd_wr,
        output sd_buff_din,
        input  sd_ack,
        input  sd_buff_addr
    );

    modport slave (
        input  sd_lba,
        input  sd_wr,
        input  sd_buff_din,
        output sd_ack,
        output sd_buff_addr
    );
endinterface

// File: rtl/nib_track_writer.sv
// Streams the buffered 13-sector NIB track back to the SD image.
// The CPU is held through busy while the write-back runs.
// A request made while busy is remembered and serviced right after DONE.
module nib_track_writer #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6,
    parameter int LBA_W   = 32
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               flush_req,
    input  logic               track_dirty,
    input  logic [TRACK_W-1:0] buf_track,
    input  logic               img_ok,
    input  logic               img_ro,
    nib_track_writer_if.master sd,
    output logic [12:0]        trk_ram_addr,
    input  logic [7:0]         trk_ram_dout,
    output logic               busy,
    output logic               dirty_clr,
    output logic               flush_done,
    output logic               flush_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             wr_q, wr_d;
    logic [3:0]       sec_q, sec_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic             saved_q, saved_d;
    logic             old_ack_q;
    logic             busy_d, dirty_clr_d, flush_done_d, flush_err_d;
    logic             ack_rise, ack_fall;
    logic [LBA_W-1:0] first_lba;

    // buf_track is stable while busy, so the first LBA is taken straight from it.
    assign first_lba = LBA_W'(SECTORS) * {{(LBA_W-TRACK_W){1'b0}}, buf_track};

    assign ack_rise = sd.sd_ack & ~old_ack_q;
    assign ack_fall = ~sd.sd_ack & old_ack_q;

    assign sd.sd_lba      = lba_q;
    assign sd.sd_wr       = wr_q;
    assign sd.sd_buff_din = trk_ram_dout;
    assign trk_ram_addr   = {sec_q, sd.sd_buff_addr};
    assign dbg_state      = state_q;

    // State and datapath registers; reset abandons any sector in flight.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lba_q      <= '0;
            wr_q       <= 1'b0;
            sec_q      <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            saved_q    <= 1'b0;
            old_ack_q  <= 1'b0;
            busy       <= 1'b0;
            dirty_clr  <= 1'b0;
            flush_done <= 1'b0;
            flush_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            wr_q       <= wr_d;
            sec_q      <= sec_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            saved_q    <= saved_d;
            old_ack_q  <= sd.sd_ack;
            busy       <= busy_d;
            dirty_clr  <= dirty_clr_d;
            flush_done <= flush_done_d;
            flush_err  <= flush_err_d;
        end
    end

    // Next-state logic: request decode, per-sector ack tracking and result pulses.
    always_comb begin
        state_d      = state_q;
        lba_d        = lba_q;
        wr_d         = wr_q;
        sec_d        = sec_q;
        pending_d    = pending_q;
        err_d        = err_q;
        saved_d      = saved_q;
        busy_d       = busy;
        dirty_clr_d  = 1'b0;
        flush_done_d = 1'b0;
        flush_err_d  = 1'b0;

        // Requests that arrive while working collapse into one pending flag.
        if (flush_req && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (flush_req || pending_q) begin
                    pending_d = 1'b0;
                    if (!track_dirty) begin
                        err_d   = 1'b0;
                        saved_d = 1'b0;
                        state_d = DONE;
                    end else if (!img_ok || img_ro) begin
                        err_d   = 1'b1;
                        saved_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        sec_d   = '0;
                        lba_d   = first_lba;
                        wr_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                if (ack_rise) begin
                    // Advance the LBA now. It is not used again until the next sector.
                    lba_d = lba_q + LBA_W'(1);
                    if (sec_q == 4'(SECTORS - 1)) begin
                        wr_d = 1'b0;
                    end
                end
                if (ack_fall) begin
                    sec_d = sec_q + 4'd1;
                    if (!wr_q) begin
                        err_d   = 1'b0;
                        saved_d = 1'b1;
                        state_d = DONE;
                    end else if (!img_ok) begin
                        wr_d    = 1'b0;
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                if (!sd.sd_ack) begin
                    err_d   = 1'b1;
                    saved_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done_d = 1'b1;
                flush_err_d  = err_q;
                dirty_clr_d  = saved_q;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
